// File: rtl/mayo_axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and address-width helper
// for the MAYO control-plane register file.
package mayo_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] { W_IDLE, W_COMMIT, W_RESP } wr_state_e;
  typedef enum logic       { R_IDLE, R_DATA }           rd_state_e;

  function automatic int axil_addr_width(input int num_regs, input int data_width);
    return $clog2(num_regs) + $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mayo_axil_strb_merge.sv
// Byte-strobe merge of new write data into an old register word.
// Purely combinational; no flow control.
module mayo_axil_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   merged_o
);

  for (genvar b = 0; b < DW / 8; b++) begin : g_byte
    assign merged_o[8*b +: 8] = strb_i[b] ? wdata_i[8*b +: 8] : old_i[8*b +: 8];
  end

endmodule

// File: rtl/mayo_axil_regfile.sv
// AXI4-Lite register file: commit one cycle after the last of AW/W, B held until BREADY, R one cycle after AR.
// MAYO_AXIL_SLVERR_EN selects SLVERR instead of OKAY for out-of-range accesses.
module mayo_axil_regfile
  import mayo_axil_pkg::*;
#(
  parameter int  C_S_AXI_DATA_WIDTH = 32,
  parameter int  NUM_REGS           = 4,
  parameter int  NUM_RO             = 0,
  localparam int C_S_AXI_ADDR_WIDTH = axil_addr_width(NUM_REGS, C_S_AXI_DATA_WIDTH)
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_stb,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int SW     = DW / 8;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int OFFW   = $clog2(SW);
  localparam int IDXW   = AW - OFFW;
  localparam int NUM_RW = NUM_REGS - NUM_RO;
`ifdef MAYO_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  wr_state_e       w_state_q, w_state_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDXW-1:0] widx_q, widx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            aw_rdy, w_rdy, b_vld, commit_en;
  logic [DW-1:0]   wr_old, wr_merged;
  logic [DW-1:0]   regs_q [NUM_RW];
  logic [NUM_REGS-1:0] stb_q;

  rd_state_e       r_state_q, r_state_d;
  logic [IDXW-1:0] ridx;
  logic [DW-1:0]   rd_word, rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            ar_rdy, r_vld;

  // Ready is masked during reset so nothing is accepted until ARESET drops.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    commit_en = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_rdy = !aw_held_q && !ARESET;
        w_rdy  = !w_held_q && !ARESET;
        if (S_AXI_AWVALID && aw_rdy) begin
          aw_held_d = 1'b1;
          widx_d    = S_AXI_AWADDR[AW-1:OFFW];
        end
        if (S_AXI_WVALID && w_rdy) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        commit_en = (int'(widx_q) < NUM_RW);
        bresp_d   = (int'(widx_q) < NUM_REGS) ? RESP_OKAY : OOR_RESP;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (widx_q == IDXW'(i)) wr_old = regs_q[i];
    end
  end

  mayo_axil_strb_merge #(.DW(DW)) u_merge (
    .old_i    (wr_old),
    .wdata_i  (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (wr_merged)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
      stb_q <= '0;
    end else begin
      stb_q <= '0;
      for (int i = 0; i < NUM_RW; i++) begin
        if (commit_en && widx_q == IDXW'(i)) begin
          regs_q[i] <= wr_merged;
          stb_q[i]  <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    if (i < NUM_RW) begin : g_rw
      assign reg_q[i*DW +: DW] = regs_q[i];
    end else begin : g_ro
      assign reg_q[i*DW +: DW] = status_in[(i-NUM_RW)*DW +: DW];
    end
  end

  // Reads see the pre-commit value when a write lands in the same cycle.
  assign ridx = S_AXI_ARADDR[AW-1:OFFW];
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDXW'(i)) rd_word = reg_q[i*DW +: DW];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_rdy    = 1'b0;
    r_vld     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_rdy = !ARESET;
        if (S_AXI_ARVALID && ar_rdy) begin
          rdata_d   = rd_word;
          rresp_d   = (int'(ridx) < NUM_REGS) ? RESP_OKAY : OOR_RESP;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_stb    = stb_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFFW-1:0],
                       S_AXI_ARADDR[OFFW-1:0], status_in};

endmodule

// File: tb/tb_mayo_axil_regfile.sv
// Bench for mayo_axil_regfile with 6 registers (top 2 read-only), 32-bit data.
module tb_mayo_axil_regfile;

  localparam logic [1:0] RESP_OK = 2'b00;
`ifdef MAYO_AXIL_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic         clk, rst;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [191:0] reg_q;
  logic [5:0]   reg_wr_stb;
  logic [63:0]  status_in;

  int           n_checks, n_errors;
  int           stb_cnt [6];
  logic [31:0]  model [4];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    int          exp_stb;
  } vec_t;
  vec_t vecs [12];

  mayo_axil_regfile #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(6), .NUM_RO(2)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_stb(reg_wr_stb), .status_in(status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) if (reg_wr_stb[i] === 1'b1) stb_cnt[i]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic int stb_total();
    int s = 0;
    for (int i = 0; i < 6; i++) s += stb_cnt[i];
    return s;
  endfunction

  // Byte-lane update rule: each set strobe bit replaces its byte.
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, b_done;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 64) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      aw_done |= aw_hs;
      w_done  |= w_hs;
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accept", aw_done && w_done, 1);
    b_done = 0; t = 0; resp = 2'bxx;
    while (!b_done && t < 64) begin
      bready = (t >= b_dly);
      if (bvalid && bready) begin
        resp = bresp;
        b_done = 1;
      end
      tick();
      t++;
    end
    bready = 1'b0;
    chk("b_handshake", b_done, 1);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done;
    int t;
    done = 0; t = 0; araddr = addr;
    while (!done && t < 64) begin
      arvalid = (t >= ar_dly);
      done = arvalid && arready;
      tick();
      t++;
    end
    arvalid = 1'b0;
    chk("ar_accept", done, 1);
    chk("r_latency", rvalid, 1);
    done = 0; t = 0; data = 'x; resp = 'x;
    while (!done && t < 64) begin
      rready = (t >= r_dly);
      if (rvalid && rready) begin
        data = rdata;
        resp = rresp;
        done = 1;
      end
      tick();
      t++;
    end
    rready = 1'b0;
    chk("r_handshake", done, 1);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd, d, want;
  logic [3:0]  s;
  logic [4:0]  a;
  int          idx, tot, before_idx;

  initial begin
    vecs[0]  = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001, RESP_OK, 0};
    vecs[1]  = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, RESP_OK, 1};
    vecs[2]  = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, RESP_OK, 2};
    vecs[3]  = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, RESP_OK, 3};
    vecs[4]  = '{5'h04, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD, RESP_OK, 1};
    vecs[5]  = '{5'h04, 32'h1122_3344, 4'h5, 32'hAA22_CC44, RESP_OK, 1};
    vecs[6]  = '{5'h10, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_0001, RESP_OK, -1};
    vecs[7]  = '{5'h14, 32'h1234_5678, 4'hF, 32'hDEAD_0002, RESP_OK, -1};
    vecs[8]  = '{5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, OOR,     -1};
    vecs[9]  = '{5'h1C, 32'h0000_ABCD, 4'hF, 32'h0000_0000, OOR,     -1};
    vecs[10] = '{5'h0B, 32'h5A5A_5A5A, 4'h8, 32'h5A00_0003, RESP_OK, 2};
    vecs[11] = '{5'h00, 32'hCAFE_BABE, 4'h3, 32'h0000_BABE, RESP_OK, 0};

    n_checks = 0; n_errors = 0;
    rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; status_in = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    tick(); tick();
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stb", reg_wr_stb, 0);
    chk("rst_reg_q_zero", |reg_q, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);
    status_in = {32'hDEAD_0002, 32'hDEAD_0001};

    for (int i = 0; i < 12; i++) begin
      tot = stb_total();
      before_idx = (vecs[i].exp_stb >= 0) ? stb_cnt[vecs[i].exp_stb] : 0;
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp);
      chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      chk($sformatf("vec%0d_stb_total", i), stb_total() - tot, (vecs[i].exp_stb >= 0) ? 1 : 0);
      if (vecs[i].exp_stb >= 0)
        chk($sformatf("vec%0d_stb_idx", i), stb_cnt[vecs[i].exp_stb] - before_idx, 1);
      idx = int'(vecs[i].addr[4:2]);
      if (idx < 4) model[idx] = merge(model[idx], vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, 0, 0, rd, resp);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
    end

    // Write latency: AW and W together, commit and strobe one cycle later.
    awaddr = 5'h0C; wdata = 32'h1357_2468; wstrb = 4'hF; bready = 1'b0;
    chk("lat_idle_ready", {awready, wready}, 2'b11);
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("lat_no_early_commit", reg_q[127:96], model[3]);
    tick();
    chk("lat_stb", reg_wr_stb, 6'b001000);
    chk("lat_reg", reg_q[127:96], 32'h1357_2468);
    tick();
    chk("lat_stb_pulse", reg_wr_stb, 0);
    chk("lat_bvalid", {bvalid, bresp}, 3'b100);
    bready = 1;
    tick();
    bready = 0;
    chk("lat_b_done", bvalid, 0);
    model[3] = 32'h1357_2468;

    // AW three cycles ahead of W, then B held off for five cycles.
    awaddr = 5'h08; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; tot = stb_total();
    chk("early_aw_ready", awready, 1);
    awvalid = 1;
    tick();
    awvalid = 0;
    chk("early_awready_low", awready, 0);
    tick(); tick();
    chk("early_wready", wready, 1);
    wvalid = 1;
    tick();
    wvalid = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("early_bp%0d", i), {bvalid, bresp, awready, wready}, 5'b10000);
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    chk("early_b_done", bvalid, 0);
    chk("early_stb_once", stb_total() - tot, 1);
    chk("early_reg", reg_q[95:64], 32'h0F0F_0F0F);
    model[2] = 32'h0F0F_0F0F;

    for (int k = 0; k < 60; k++) begin
      idx = $urandom_range(0, 7);
      a = {3'(idx), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom);
        tot = stb_total();
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
        chk($sformatf("rnd%0d_bresp", k), resp, (idx < 6) ? RESP_OK : OOR);
        chk($sformatf("rnd%0d_stb", k), stb_total() - tot, (idx < 4) ? 1 : 0);
        if (idx < 4) model[idx] = merge(model[idx], d, s);
      end else begin
        status_in = {$urandom, $urandom};
        if (idx < 4)       want = model[idx];
        else if (idx == 4) want = status_in[31:0];
        else if (idx == 5) want = status_in[63:32];
        else               want = 32'h0;
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), rd, resp);
        chk($sformatf("rnd%0d_rdata", k), rd, want);
        chk($sformatf("rnd%0d_rresp", k), resp, (idx < 6) ? RESP_OK : OOR);
      end
    end

    // Reset after AW accepted but before W arrives.
    status_in = '0;
    awaddr = 5'h04;
    chk("mr_awready", awready, 1);
    awvalid = 1;
    tick();
    awvalid = 0;
    chk("mr_aw_held", awready, 0);
    tick();
    rst = 1;
    tick(); tick();
    chk("mr_in_reset", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    rst = 0;
    tick();
    chk("mr_after", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    chk("mr_reg_q_zero", |reg_q, 0);
    chk("mr_no_stb", reg_wr_stb, 0);
    axi_write(5'h04, 32'h600D_F00D, 4'hF, 0, 0, 0, resp);
    chk("mr_post_bresp", resp, RESP_OK);
    axi_read(5'h04, 0, 0, rd, resp);
    chk("mr_post_rdata", rd, 32'h600D_F00D);
    axi_read(5'h00, 0, 0, rd, resp);
    chk("mr_reg0_cleared", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mayo_axil_regfile.md
# mayo_axil_regfile

Parametrised AXI4-Lite slave register file for the MAYO accelerator control plane, generalising the fixed four-register 32-bit S00_AXI interface. It adds configurable register count, data width and byte strobes, read-only status registers fed from the core, per-register write strobes toward the core, and decoded error responses. It sits between the processor interconnect and the MAYO core's control/status logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus and register width; 32 or 64 only.
- NUM_REGS, 4, total registers, 2..256; need not be a power of two.
- NUM_RO, 0, number of read-only status registers, occupying the top indices NUM_REGS-NUM_RO..NUM_REGS-1; 0..NUM_REGS-1.
- Derived localparam C_S_AXI_ADDR_WIDTH = clog2(NUM_REGS) + clog2(C_S_AXI_DATA_WIDTH/8).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite, widths from C_S_AXI_ADDR_WIDTH/C_S_AXI_DATA_WIDTH; PROT ignored.
- reg_q  out  NUM_REGS*C_S_AXI_DATA_WIDTH  current register contents, register i at slice i; RO slots mirror status_in.
- reg_wr_stb  out  NUM_REGS  one-cycle pulse on the cycle register i is written (RW registers only).
- status_in  in  max(NUM_RO,1)*C_S_AXI_DATA_WIDTH  status word j read at register index NUM_REGS-NUM_RO+j; sampled, no CDC.

## Operation
- Register index = ADDR[C_S_AXI_ADDR_WIDTH-1 : clog2(DW/8)]; low byte-offset bits ignored. Index >= NUM_REGS is out of range.
- Write FSM W_IDLE -> W_COMMIT -> W_RESP -> W_IDLE. In W_IDLE, AWREADY = !aw_held, WREADY = !w_held; AW and W accepted independently in either order or same cycle, each latched. When both held, go W_COMMIT: apply WSTRB byte-wise to the addressed RW register, pulse its reg_wr_stb. W_RESP: BVALID high, held until BREADY, then clear aw_held/w_held.
- Writes to RO registers: no state change, no strobe, BRESP OKAY.
- Read FSM R_IDLE -> R_DATA. R_IDLE: ARREADY = 1; on handshake capture RDATA/RRESP from current register value (old value if a commit occurs in the same cycle). R_DATA: RVALID high with RDATA stable until RREADY, then R_IDLE.
- Read and write FSMs are fully independent; both may be active together.
- Out-of-range behaviour: see Configuration.

## Timing
- Reset: all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr_stb = 0; BRESP, RRESP, RDATA = 0; FSMs in IDLE with held flags cleared. READY signals assert the first cycle after ARESET deasserts.
- Write: last of AW/W handshake at edge N -> register and reg_wr_stb updated edge N+1 -> BVALID high from edge N+2. No new AW/W accepted until B handshake.
- Read: AR handshake at edge N -> RVALID high from edge N+1; ARREADY low while in R_DATA.
- Reset mid-transaction aborts it; no partial register update; no B/R issued for the aborted request.
- Throughput: one write per 3 cycles, one read per 2 cycles at zero backpressure.

## Configuration
- MAYO_AXIL_SLVERR_EN defined: out-of-range write -> BRESP SLVERR (2'b10), no update; out-of-range read -> RRESP SLVERR, RDATA 0.
- Undefined: out-of-range accesses respond OKAY; writes dropped, reads return 0. Timing identical in both builds.

## Structure
- Package mayo_axil_pkg: AXI response constants (OKAY, SLVERR), write/read FSM state enums, clog2-based address-width helper function.
- One sub-module: mayo_axil_strb_merge (byte-strobe merge of WDATA into old register value, parametrised by width).

## Test plan
- NUM_REGS=6, DW=32: write 0x1,0x2,0x3,0x4 to addresses 0x0..0xC, read back -> identical data, all RESP OKAY, reg_wr_stb pulses once per write.
- Register 1 = 0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> reads 0xAA22CC44.
- AWVALID 3 cycles before WVALID, then BREADY held low 5 cycles -> AWREADY drops after AW handshake, BVALID stays high with OKAY until BREADY; register updated exactly once.
- NUM_RO=2, status_in words 0xDEAD0001/0xDEAD0002: read indices 4,5 -> those values; write 0xFFFFFFFF to index 4 -> OKAY, no strobe, readback unchanged.
- Access address 0x18 (index 6) -> with MAYO_AXIL_SLVERR_EN BRESP/RRESP = 2'b10, RDATA 0; without it OKAY, RDATA 0.
- ARESET asserted after AW accepted but before W -> after release, all READY high, no BVALID, register unchanged, reg_q all zero.
